// File: rtl/stopwatch_core.sv
// Minutes/seconds/centiseconds stopwatch-timer core with internal tick prescaler.
// Define STOPWATCH_LAP_EN to build lap capture; otherwise the lap outputs read as zero.
module stopwatch_core #(
    parameter int TICK_DIV = 1,
    parameter int MIN_MAX  = 99,
    parameter int MIN_W    = 7
) (
    input  logic             CLK_100Hz,
    input  logic             reset_n,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             load,
    input  logic [MIN_W-1:0] load_mins,
    input  logic [5:0]       load_secs,
    input  logic [6:0]       load_decs,
    input  logic             count_down,
    input  logic             lap,
    output logic [MIN_W-1:0] mins,
    output logic [5:0]       secs,
    output logic [6:0]       decs,
    output logic [MIN_W-1:0] lap_mins,
    output logic [5:0]       lap_secs,
    output logic [6:0]       lap_decs,
    output logic             lap_valid,
    output logic             running,
    output logic             overflow,
    output logic             done
);
    localparam logic [1:0] ST_STOP = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_END  = 2'd2;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [MIN_W-1:0] MINS_TOP = MIN_W'(MIN_MAX);
    localparam logic [MIN_W-1:0] MINS_ONE = MIN_W'(1);
    localparam logic [MIN_W-1:0] MINS_NIL = {MIN_W{1'b0}};

    logic [1:0]       state_q, state_d;
    logic             dir_q, dir_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [MIN_W-1:0] mins_q, mins_d;
    logic [5:0]       secs_q, secs_d;
    logic [6:0]       decs_q, decs_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             run_q, run_d;
    logic             ss_prev_q, ss_arm_q;
    logic             ss_rise_s, at_max_s, all_zero_s, last_s;

    // The arm bit blocks an edge from an input that was already high when reset released.
    assign ss_rise_s  = start_stop & ~ss_prev_q & ss_arm_q;
    assign at_max_s   = (mins_q == MINS_TOP) && (secs_q == 6'd59) && (decs_q == 7'd99);
    assign all_zero_s = (mins_q == MINS_NIL) && (secs_q == 6'd0) && (decs_q == 7'd0);
    assign last_s     = (mins_q == MINS_NIL) && (secs_q == 6'd0) && (decs_q <= 7'd1);

    // Next-state: clear > load > start/stop edge > tick.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pre_d   = pre_q;
        mins_d  = mins_q;
        secs_d  = secs_q;
        decs_d  = decs_q;
        ovf_d   = ovf_q;
        done_d  = done_q;
        if (clear) begin
            state_d = ST_STOP;
            pre_d   = {PW{1'b0}};
            mins_d  = MINS_NIL;
            secs_d  = 6'd0;
            decs_d  = 7'd0;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
        end else if (load && (state_q != ST_RUN)) begin
            state_d = ST_STOP;
            pre_d   = {PW{1'b0}};
            mins_d  = (load_mins > MINS_TOP) ? MINS_TOP : load_mins;
            secs_d  = (load_secs > 6'd59) ? 6'd59 : load_secs;
            decs_d  = (load_decs > 7'd99) ? 7'd99 : load_decs;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
        end else if (ss_rise_s) begin
            pre_d = {PW{1'b0}};
            case (state_q)
                ST_STOP: begin
                    if (!(count_down && all_zero_s)) begin
                        state_d = ST_RUN;
                        dir_d   = count_down;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                ST_RUN:  state_d = ST_STOP;
                ST_END:  state_d = ST_END;
                default: state_d = ST_STOP;
            endcase
        end else if (state_q == ST_RUN) begin
            if (pre_q == PRE_LAST) begin
                pre_d = {PW{1'b0}};
                if (!dir_q) begin
                    if (at_max_s) begin
                        ovf_d   = 1'b1;
                        state_d = ST_END;
                    end else if (decs_q == 7'd99) begin
                        decs_d = 7'd0;
                        if (secs_q == 6'd59) begin
                            secs_d = 6'd0;
                            mins_d = mins_q + MINS_ONE;
                        end else begin
                            secs_d = secs_q + 6'd1;
                        end
                    end else begin
                        decs_d = decs_q + 7'd1;
                    end
                end else begin
                    if (last_s) begin
                        decs_d  = 7'd0;
                        done_d  = 1'b1;
                        state_d = ST_END;
                    end else if (decs_q == 7'd0) begin
                        decs_d = 7'd99;
                        if (secs_q == 6'd0) begin
                            secs_d = 6'd59;
                            mins_d = mins_q - MINS_ONE;
                        end else begin
                            secs_d = secs_q - 6'd1;
                        end
                    end else begin
                        decs_d = decs_q - 7'd1;
                    end
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end else begin
            pre_d = {PW{1'b0}};
        end
        run_d = (state_d == ST_RUN);
    end

    // Core state registers and start/stop edge history.
    always_ff @(posedge CLK_100Hz) begin
        if (!reset_n) begin
            state_q   <= ST_STOP;
            dir_q     <= 1'b0;
            pre_q     <= {PW{1'b0}};
            mins_q    <= MINS_NIL;
            secs_q    <= 6'd0;
            decs_q    <= 7'd0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            run_q     <= 1'b0;
            ss_prev_q <= 1'b0;
            ss_arm_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            pre_q     <= pre_d;
            mins_q    <= mins_d;
            secs_q    <= secs_d;
            decs_q    <= decs_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            run_q     <= run_d;
            ss_prev_q <= start_stop;
            ss_arm_q  <= ss_arm_q | ~start_stop;
        end
    end

    assign mins     = mins_q;
    assign secs     = secs_q;
    assign decs     = decs_q;
    assign running  = run_q;
    assign overflow = ovf_q;
    assign done     = done_q;

`ifdef STOPWATCH_LAP_EN
    logic [MIN_W-1:0] lap_mins_q;
    logic [5:0]       lap_secs_q;
    logic [6:0]       lap_decs_q;
    logic             lap_valid_q, lap_prev_q, lap_arm_q, lap_rise_s;

    assign lap_rise_s = lap & ~lap_prev_q & lap_arm_q;

    // Lap snapshot takes the count as it stood before this cycle's update.
    always_ff @(posedge CLK_100Hz) begin
        if (!reset_n) begin
            lap_mins_q  <= MINS_NIL;
            lap_secs_q  <= 6'd0;
            lap_decs_q  <= 7'd0;
            lap_valid_q <= 1'b0;
            lap_prev_q  <= 1'b0;
            lap_arm_q   <= 1'b0;
        end else begin
            lap_prev_q <= lap;
            lap_arm_q  <= lap_arm_q | ~lap;
            if (clear) begin
                lap_mins_q  <= MINS_NIL;
                lap_secs_q  <= 6'd0;
                lap_decs_q  <= 7'd0;
                lap_valid_q <= 1'b0;
            end else if (lap_rise_s && (state_q != ST_END)) begin
                lap_mins_q  <= mins_q;
                lap_secs_q  <= secs_q;
                lap_decs_q  <= decs_q;
                lap_valid_q <= 1'b1;
            end
        end
    end

    assign lap_mins  = lap_mins_q;
    assign lap_secs  = lap_secs_q;
    assign lap_decs  = lap_decs_q;
    assign lap_valid = lap_valid_q;
`else
    logic lap_unused_s;
    assign lap_unused_s = lap;
    assign lap_mins     = MINS_NIL;
    assign lap_secs     = 6'd0;
    assign lap_decs     = 7'd0;
    assign lap_valid    = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: DUT A (TICK_DIV=1, MIN_MAX=99) and DUT B (TICK_DIV=4, MIN_MAX=2)
// against a model that tracks the count as total centiseconds.
module tb_stopwatch_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic a_ss, a_clr, a_ld, a_cd, a_lap;
    logic [6:0] a_lm; logic [5:0] a_ls; logic [6:0] a_lc;
    logic [6:0] a_mins, a_lmins; logic [5:0] a_secs, a_lsecs; logic [6:0] a_decs, a_ldecs;
    logic a_lv, a_running, a_ovf, a_done;

    logic b_ss, b_clr, b_ld, b_cd, b_lap;
    logic [2:0] b_lm; logic [5:0] b_ls; logic [6:0] b_lc;
    logic [2:0] b_mins, b_lmins; logic [5:0] b_secs, b_lsecs; logic [6:0] b_decs, b_ldecs;
    logic b_lv, b_running, b_ovf, b_done;

    stopwatch_core #(.TICK_DIV(1), .MIN_MAX(99), .MIN_W(7)) dut_a (
        .CLK_100Hz(clk), .reset_n(rst_n), .start_stop(a_ss), .clear(a_clr), .load(a_ld),
        .load_mins(a_lm), .load_secs(a_ls), .load_decs(a_lc), .count_down(a_cd), .lap(a_lap),
        .mins(a_mins), .secs(a_secs), .decs(a_decs), .lap_mins(a_lmins), .lap_secs(a_lsecs),
        .lap_decs(a_ldecs), .lap_valid(a_lv), .running(a_running), .overflow(a_ovf), .done(a_done));

    stopwatch_core #(.TICK_DIV(4), .MIN_MAX(2), .MIN_W(3)) dut_b (
        .CLK_100Hz(clk), .reset_n(rst_n), .start_stop(b_ss), .clear(b_clr), .load(b_ld),
        .load_mins(b_lm), .load_secs(b_ls), .load_decs(b_lc), .count_down(b_cd), .lap(b_lap),
        .mins(b_mins), .secs(b_secs), .decs(b_decs), .lap_mins(b_lmins), .lap_secs(b_lsecs),
        .lap_decs(b_ldecs), .lap_valid(b_lv), .running(b_running), .overflow(b_ovf), .done(b_done));

    logic [43:0] got_a, got_b;
    assign got_a = {a_mins, a_secs, a_decs, a_lmins, a_lsecs, a_ldecs, a_lv, a_running, a_ovf, a_done};
    assign got_b = {4'd0, b_mins, b_secs, b_decs, 4'd0, b_lmins, b_lsecs, b_ldecs,
                    b_lv, b_running, b_ovf, b_done};

    int tests = 0;
    int fails = 0;

    // Reference model: 0=STOP 1=RUN 2=END, count kept as total centiseconds.
    int m_st[2], m_t[2], m_dir[2], m_pre[2], m_lapt[2];
    bit m_ovf[2], m_done[2], m_lapv[2], m_ssp[2], m_ssa[2], m_lpp[2], m_lpa[2];

    task automatic model_step(input int id, input bit rn, input bit clr, input bit ld, input bit ss,
                              input bit cd, input bit lp, input int lm, input int ls, input int lc);
        int tdiv, mmax, tmax, old_t, old_st;
        bit ssr, lpr;
        tdiv = (id == 0) ? 1 : 4;
        mmax = (id == 0) ? 99 : 2;
        tmax = mmax * 6000 + 5999;
        if (!rn) begin
            m_st[id] = 0; m_t[id] = 0; m_dir[id] = 0; m_pre[id] = 0; m_lapt[id] = 0;
            m_ovf[id] = 0; m_done[id] = 0; m_lapv[id] = 0;
            m_ssp[id] = 0; m_ssa[id] = 0; m_lpp[id] = 0; m_lpa[id] = 0;
            return;
        end
        ssr = ss && !m_ssp[id] && m_ssa[id];
        lpr = lp && !m_lpp[id] && m_lpa[id];
        m_ssp[id] = ss; m_ssa[id] = m_ssa[id] || !ss;
        m_lpp[id] = lp; m_lpa[id] = m_lpa[id] || !lp;
        old_t = m_t[id]; old_st = m_st[id];
        if (clr) begin
            m_t[id] = 0; m_lapt[id] = 0; m_lapv[id] = 0; m_ovf[id] = 0; m_done[id] = 0;
            m_pre[id] = 0; m_st[id] = 0;
            return;
        end
        if (lpr && old_st != 2) begin
            m_lapt[id] = old_t; m_lapv[id] = 1;
        end
        if (ld && m_st[id] != 1) begin
            if (lc > 99) lc = 99;
            if (ls > 59) ls = 59;
            if (lm > mmax) lm = mmax;
            m_t[id] = lm * 6000 + ls * 100 + lc;
            m_ovf[id] = 0; m_done[id] = 0; m_st[id] = 0; m_pre[id] = 0;
        end else if (ssr) begin
            m_pre[id] = 0;
            if (m_st[id] == 0) begin
                if (!(cd && m_t[id] == 0)) begin m_st[id] = 1; m_dir[id] = cd; end
            end else if (m_st[id] == 1) m_st[id] = 0;
        end else if (m_st[id] == 1) begin
            if (m_pre[id] == tdiv - 1) begin
                m_pre[id] = 0;
                if (m_dir[id] == 0) begin
                    if (m_t[id] == tmax) begin m_ovf[id] = 1; m_st[id] = 2; end
                    else m_t[id] = m_t[id] + 1;
                end else begin
                    m_t[id] = m_t[id] - 1;
                    if (m_t[id] == 0) begin m_done[id] = 1; m_st[id] = 2; end
                end
            end else m_pre[id] = m_pre[id] + 1;
        end else m_pre[id] = 0;
    endtask

    function automatic logic [43:0] exp_vec(input int id);
        int t, lt;
        bit lv;
        t = m_t[id];
`ifdef STOPWATCH_LAP_EN
        lt = m_lapt[id]; lv = m_lapv[id];
`else
        lt = 0; lv = 0;
`endif
        return {7'(t / 6000), 6'((t / 100) % 60), 7'(t % 100),
                7'(lt / 6000), 6'((lt / 100) % 60), 7'(lt % 100),
                lv, (m_st[id] == 1), m_ovf[id], m_done[id]};
    endfunction

    always @(posedge clk) begin
        model_step(0, rst_n, a_clr, a_ld, a_ss, a_cd, a_lap, int'(a_lm), int'(a_ls), int'(a_lc));
        model_step(1, rst_n, b_clr, b_ld, b_ss, b_cd, b_lap, int'(b_lm), int'(b_ls), int'(b_lc));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; a_ss = 1'b1; cyc(3);
        tests++; if (got_a !== 44'd0) begin fails++; $display("FAIL reset_a got=%h exp=0", got_a); end
        tests++; if (got_b !== 44'd0) begin fails++; $display("FAIL reset_b got=%h exp=0", got_b); end
        rst_n = 1'b1; cyc(5);
        tests++; if (a_running !== 1'b0) begin fails++; $display("FAIL held_start got=%b exp=0", a_running); end
        a_ss = 1'b0; cyc(1); a_ss = 1'b1; cyc(1); a_ss = 1'b0;
        tests++; if (a_running !== 1'b1) begin fails++; $display("FAIL rearmed_start got=%b exp=1", a_running); end
        a_clr = 1'b1; cyc(1); a_clr = 1'b0;
        tests++; if (got_a !== exp_vec(0)) begin fails++; $display("FAIL clear_a got=%h exp=%h", got_a, exp_vec(0)); end
    endtask

    task automatic test_run_minute;
        a_cd = 1'b0; a_ss = 1'b1; cyc(1); a_ss = 1'b0; cyc(6000);
        tests++; if ({a_mins, a_secs, a_decs, a_running} !== {7'd1, 6'd0, 7'd0, 1'b1}) begin
            fails++; $display("FAIL minute got=%0d:%0d:%0d run=%b exp=1:0:0 run=1", a_mins, a_secs, a_decs, a_running); end
        tests++; if (got_a !== exp_vec(0)) begin fails++; $display("FAIL minute_model got=%h exp=%h", got_a, exp_vec(0)); end
        a_ss = 1'b1; cyc(1); a_ss = 1'b0; cyc(100);
        tests++; if ({a_mins, a_secs, a_decs, a_running} !== {7'd1, 6'd0, 7'd0, 1'b0}) begin
            fails++; $display("FAIL frozen got=%0d:%0d:%0d run=%b exp=1:0:0 run=0", a_mins, a_secs, a_decs, a_running); end
    endtask

    task automatic test_overflow;
        b_clr = 1'b1; cyc(1); b_clr = 1'b0;
        b_ld = 1'b1; b_lm = 3'd7; b_ls = 6'd63; b_lc = 7'd127; cyc(1); b_ld = 1'b0;
        tests++; if ({b_mins, b_secs, b_decs} !== {3'd2, 6'd59, 7'd99}) begin
            fails++; $display("FAIL clamp got=%0d:%0d:%0d exp=2:59:99", b_mins, b_secs, b_decs); end
        b_ld = 1'b1; b_ls = 6'd59; b_lc = 7'd98; cyc(1); b_ld = 1'b0;
        b_cd = 1'b0; b_ss = 1'b1; cyc(1); b_ss = 1'b0; cyc(4);
        tests++; if ({b_decs, b_running, b_ovf} !== {7'd99, 1'b1, 1'b0}) begin
            fails++; $display("FAIL ovf_tick1 got=%0d run=%b ovf=%b exp=99 1 0", b_decs, b_running, b_ovf); end
        cyc(4);
        tests++; if ({b_mins, b_secs, b_decs, b_running, b_ovf} !== {3'd2, 6'd59, 7'd99, 1'b0, 1'b1}) begin
            fails++; $display("FAIL ovf_hold got=%0d:%0d:%0d run=%b ovf=%b", b_mins, b_secs, b_decs, b_running, b_ovf); end
        b_ss = 1'b1; cyc(1); b_ss = 1'b0; cyc(8);
        tests++; if ({b_running, b_ovf} !== 2'b01) begin fails++; $display("FAIL end_ignores_start got=%b%b exp=01", b_running, b_ovf); end
        tests++; if (got_b !== exp_vec(1)) begin fails++; $display("FAIL ovf_model got=%h exp=%h", got_b, exp_vec(1)); end
        b_clr = 1'b1; cyc(1); b_clr = 1'b0;
        tests++; if (got_b !== 44'd0) begin fails++; $display("FAIL ovf_clear got=%h exp=0", got_b); end
    endtask

    task automatic test_down;
        a_clr = 1'b1; cyc(1); a_clr = 1'b0;
        a_ld = 1'b1; a_lm = 7'd0; a_ls = 6'd1; a_lc = 7'd0; cyc(1); a_ld = 1'b0;
        a_cd = 1'b1; a_ss = 1'b1; cyc(1); a_ss = 1'b0; cyc(1);
        tests++; if ({a_mins, a_secs, a_decs, a_running} !== {7'd0, 6'd0, 7'd99, 1'b1}) begin
            fails++; $display("FAIL down_first got=%0d:%0d:%0d run=%b exp=0:0:99 1", a_mins, a_secs, a_decs, a_running); end
        cyc(99);
        tests++; if ({a_mins, a_secs, a_decs, a_running, a_done} !== {7'd0, 6'd0, 7'd0, 1'b0, 1'b1}) begin
            fails++; $display("FAIL down_done got=%0d:%0d:%0d run=%b done=%b", a_mins, a_secs, a_decs, a_running, a_done); end
        a_ss = 1'b1; cyc(1); a_ss = 1'b0; cyc(3);
        tests++; if ({a_running, a_done} !== 2'b01) begin fails++; $display("FAIL down_end_start got=%b%b exp=01", a_running, a_done); end
        a_clr = 1'b1; cyc(1); a_clr = 1'b0;
        a_ss = 1'b1; cyc(1); a_ss = 1'b0; cyc(2);
        tests++; if ({a_running, a_done} !== 2'b00) begin fails++; $display("FAIL zero_down_start got=%b%b exp=00", a_running, a_done); end
        a_cd = 1'b0;
    endtask

    task automatic test_tickdiv;
        b_clr = 1'b1; cyc(1); b_clr = 1'b0;
        b_cd = 1'b0; b_ss = 1'b1; cyc(1); b_ss = 1'b0; cyc(3);
        tests++; if ({b_decs, b_running} !== {7'd0, 1'b1}) begin fails++; $display("FAIL div_pre got=%0d run=%b exp=0 1", b_decs, b_running); end
        cyc(1);
        tests++; if (b_decs !== 7'd1) begin fails++; $display("FAIL div_tick1 got=%0d exp=1", b_decs); end
        cyc(4);
        tests++; if (b_decs !== 7'd2) begin fails++; $display("FAIL div_tick2 got=%0d exp=2", b_decs); end
        b_ld = 1'b1; b_lm = 3'd1; b_ls = 6'd5; b_lc = 7'd5; cyc(4); b_ld = 1'b0;
        tests++; if ({b_mins, b_secs, b_decs, b_running} !== {3'd0, 6'd0, 7'd3, 1'b1}) begin
            fails++; $display("FAIL load_in_run got=%0d:%0d:%0d run=%b exp=0:0:3 1", b_mins, b_secs, b_decs, b_running); end
        b_clr = 1'b1; cyc(1); b_clr = 1'b0;
    endtask

    task automatic test_lap;
        logic [19:0] exp_lap;
        a_clr = 1'b1; cyc(1); a_clr = 1'b0;
        a_ld = 1'b1; a_lm = 7'd0; a_ls = 6'd3; a_lc = 7'd20; cyc(1); a_ld = 1'b0;
        a_cd = 1'b0; a_ss = 1'b1; cyc(1); a_ss = 1'b0; cyc(7);
        tests++; if ({a_secs, a_decs} !== {6'd3, 7'd27}) begin fails++; $display("FAIL lap_pre got=%0d:%0d exp=3:27", a_secs, a_decs); end
        a_lap = 1'b1; cyc(1); a_lap = 1'b0;
`ifdef STOPWATCH_LAP_EN
        exp_lap = {7'd0, 6'd3, 7'd27};
`else
        exp_lap = 20'd0;
`endif
        tests++; if ({a_lmins, a_lsecs, a_ldecs} !== exp_lap) begin
            fails++; $display("FAIL lap_capture got=%0d:%0d:%0d", a_lmins, a_lsecs, a_ldecs); end
        tests++; if ({a_secs, a_decs, a_running} !== {6'd3, 7'd28, 1'b1}) begin
            fails++; $display("FAIL lap_live got=%0d:%0d run=%b exp=3:28 1", a_secs, a_decs, a_running); end
        cyc(5);
        tests++; if (got_a !== exp_vec(0)) begin fails++; $display("FAIL lap_model got=%h exp=%h", got_a, exp_vec(0)); end
        a_clr = 1'b1; a_ss = 1'b1; cyc(1); a_clr = 1'b0; a_ss = 1'b0; cyc(3);
        tests++; if (got_a !== 44'd0) begin fails++; $display("FAIL clear_wins got=%h exp=0", got_a); end
    endtask

    task automatic test_reset_midrun;
        a_ss = 1'b1; cyc(1); a_ss = 1'b0; cyc(10);
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        tests++; if (got_a !== 44'd0) begin fails++; $display("FAIL midrun_reset got=%h exp=0", got_a); end
        cyc(3);
        tests++; if (a_running !== 1'b0) begin fails++; $display("FAIL post_reset_stop got=%b exp=0", a_running); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 999) != 0);
            a_clr = ($urandom_range(0, 63) == 0); b_clr = ($urandom_range(0, 63) == 0);
            a_ld  = ($urandom_range(0, 31) == 0); b_ld  = ($urandom_range(0, 31) == 0);
            a_ss  = ($urandom_range(0, 7) == 0);  b_ss  = ($urandom_range(0, 7) == 0);
            a_lap = ($urandom_range(0, 3) == 0);  b_lap = ($urandom_range(0, 3) == 0);
            a_cd  = $urandom_range(0, 1);         b_cd  = $urandom_range(0, 1);
            a_lm = 7'($urandom); a_ls = 6'($urandom); a_lc = 7'($urandom);
            b_lm = 3'($urandom); b_ls = 6'($urandom); b_lc = 7'($urandom);
            cyc(1);
            tests++; if (got_a !== exp_vec(0)) begin fails++; $display("FAIL rand_a i=%0d got=%h exp=%h", i, got_a, exp_vec(0)); end
            tests++; if (got_b !== exp_vec(1)) begin fails++; $display("FAIL rand_b i=%0d got=%h exp=%h", i, got_b, exp_vec(1)); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_ss = 1'b0; a_clr = 1'b0; a_ld = 1'b0; a_cd = 1'b0; a_lap = 1'b0;
        a_lm = 7'd0; a_ls = 6'd0; a_lc = 7'd0;
        b_ss = 1'b0; b_clr = 1'b0; b_ld = 1'b0; b_cd = 1'b0; b_lap = 1'b0;
        b_lm = 3'd0; b_ls = 6'd0; b_lc = 7'd0;
        test_reset();
        test_run_minute();
        test_overflow();
        test_down();
        test_tickdiv();
        test_lap();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Parametrised single-clock stopwatch/timer core: counts minutes/seconds/hundredths up or down from a centisecond tick derived by an internal prescaler, with lap capture, preset load, a sticky overflow flag and a countdown-complete flag. Control inputs are synchronous levels, edge-detected internally; no derived signal is used as a clock. Sits between the button debouncers and the display/BCD formatting logic, serving both stopwatch and timer modes.

## Interface
- TICK_DIV, 1: clock cycles per centisecond tick (≥1); 1 means CLK_100Hz is a true 100 Hz clock.
- MIN_MAX, 99: maximum minutes value.
- MIN_W, 7: minutes field width; must satisfy 2^MIN_W > MIN_MAX.

- CLK_100Hz  in  1  sole clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start_stop  in  1  level; rising edge toggles run/stop.
- clear  in  1  level; synchronous clear, high-priority.
- load  in  1  level; while high and not RUN, preset counters.
- load_mins / load_secs / load_decs  in  MIN_W / 6 / 7  preset values.
- count_down  in  1  direction, sampled on STOP→RUN.
- lap  in  1  level; rising edge captures lap snapshot.
- mins / secs / decs  out  MIN_W / 6 / 7  live count.
- lap_mins / lap_secs / lap_decs  out  MIN_W / 6 / 7  captured count.
- lap_valid  out  1  sticky, snapshot held.
- running  out  1  high in RUN.
- overflow  out  1  sticky, up-count reached its ceiling.
- done  out  1  sticky, down-count reached zero.

## Operation
- States: STOP, RUN, END. Reset → STOP; all outputs, prescaler, direction register and edge-detect history = 0.
- Edges: rise = in & ~prev, prev registered every cycle; an input held high through reset release produces no edge until it drops and rises again.
- Per-cycle priority: reset_n low > clear > load > start_stop edge > tick. Lap capture is independent.
- clear (any state): counters, lap regs, lap_valid, overflow, done, prescaler = 0; state → STOP.
- load (STOP or END only, ignored in RUN): counters ← clamped presets (decs>99→99, secs>59→59, mins>MIN_MAX→MIN_MAX); done, overflow cleared; state → STOP.
- start_stop edge: STOP→RUN (direction ← count_down); RUN→STOP; END ignores it. STOP→RUN with count_down=1 and counters all zero: ignored, stays STOP.
- Prescaler: 0..TICK_DIV−1, counts only in RUN, forced to 0 otherwise; tick when prescaler = TICK_DIV−1 in RUN.
- Up tick: decs+1; at 99 → 0 and carry to secs; secs at 59 → 0 and carry to mins. At MIN_MAX:59:99 a tick holds the counters at MIN_MAX:59:99, sets overflow, state → END.
- Down tick: decs−1; at 0 → 99 and borrow; secs at 0 → 59 and borrow from mins. Reaching 0:00:00 sets done, state → END in the same cycle.
- Lap edge (STOP or RUN): lap regs ← live counters as registered before this cycle's update; lap_valid ← 1. In END: ignored.

## Timing
- Start edge sampled at edge N → running = 1 after N; first count change after edge N+TICK_DIV, then every TICK_DIV cycles.
- Stop edge at edge M → running = 0 after M; a tick due at M is suppressed.
- overflow/done rise on the same edge as the terminal count; running falls on that edge.
- Lap outputs valid one cycle after the lap edge sample.
- All outputs registered; no combinational input→output paths.

## Configuration
- STOPWATCH_LAP_EN defined: lap capture as above.
- Undefined: lap input ignored; lap_mins/lap_secs/lap_decs and lap_valid tied to 0; lap registers not built.

## Test plan
- TICK_DIV=1: reset, start edge, run 6000 cycles → 1:00:00, running=1; stop edge → count frozen for 100 cycles.
- Up overflow, MIN_MAX=2: load 2:59:98, start, 2 ticks → holds 2:59:99, overflow=1, running=0; further start edges ignored; clear → 0:00:00, overflow=0.
- Down mode: load 0:01:00, count_down=1, start → 0:00:99 after 1 tick, 0:00:00 after 100 ticks with done=1, state END; start at 0:00:00 ignored.
- TICK_DIV=4: start at edge N → decs=1 after edge N+4, decs=2 after N+8; load asserted during RUN → no effect.
- Lap in RUN at 0:03:27 → lap regs 0:03:27, lap_valid=1, live count continues; clear and start_stop on the same cycle → clear wins, STOP.
- reset_n low mid-RUN for one cycle → all outputs 0, STOP; start_stop held high across release → no start until low→high.
